prefix_pre_stage: RTL and testbench

//   Pre-processing stage upstream of the prefix_node tree in the parallel-prefix adder.
//   - Accepts operand pairs and a carry-in over a valid/ready handshake.
//   - Forms the bitwise generate/propagate vectors that feed the first tree level.
//   - Holds them in a registered output stage backed by a one-entry skid buffer, so
//     the upstream ready never depends combinationally on downstream ready.
//

---
 rtl/prefix_pre_stage_if.sv | 31 +++
 rtl/prefix_pre_stage.sv | 100 ++++++++++
 tb/tb_prefix_pre_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prefix_pre_stage_if.sv
// prefix_pre_stage_if
//   Bundles the operand-side and result-side handshake of the prefix pre-stage.
//   Operand side : in_valid, in_ready, a, b, carry_in
//   Result side  : out_valid, out_ready, gen_out, prop_out, cin_out, all_prop
//   master : the environment (drives operands and out_ready)
//   slave  : the pre-stage itself
interface prefix_pre_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gen_out;
  logic [WIDTH-1:0] prop_out;
  logic             cin_out;
  logic             all_prop;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, gen_out, prop_out, cin_out, all_prop
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, gen_out, prop_out, cin_out, all_prop
  );
endinterface

// File: rtl/prefix_pre_stage.sv
// prefix_pre_stage
//   Forms per-bit generate (a & b) and propagate (a ^ b) vectors, the whole-word
//   propagate and the carry-in for the first level of the prefix tree. Results
//   sit in a registered output entry backed by a one-entry skid entry, so
//   in_ready depends only on registered state.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : prefix_pre_stage_if.slave (operand and result handshakes)
module prefix_pre_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prefix_pre_stage_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             cin;
    logic             allp;
  } beat_t;

  state_t state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   accept;
  logic   drain;

  always_comb begin
    in_beat      = '0;
    in_beat.gen  = bus.a & bus.b;
    in_beat.prop = bus.a ^ bus.b;
    in_beat.cin  = bus.carry_in;
    in_beat.allp = &(bus.a ^ bus.b);
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.gen_out   = main_q.gen;
  assign bus.prop_out  = main_q.prop;
  assign bus.cin_out   = main_q.cin;
  assign bus.all_prop  = main_q.allp;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = in_beat;
        end else if (accept) begin
          skid_d  = in_beat;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // The skid entry always holds the younger beat, so it refills main.
        if (drain) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_prefix_pre_stage.sv
module tb_prefix_pre_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  prefix_pre_stage_if #(.WIDTH(8)) bus ();

  prefix_pre_stage #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = c;
  endtask

  logic [16:0] exp_q[$];
  logic [16:0] head;
  logic [7:0]  ea, eb;
  int          sent, recv;
  logic        holding;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_gen",       bus.gen_out,   0);
    chk("rst_prop",      bus.prop_out,  0);
    chk("rst_cin",       bus.cin_out,   0);
    chk("rst_allp",      bus.all_prop,  0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single beat, one-cycle latency
    drive(8'hF0, 8'h3C, 1'b1);
    chk("t1_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_gen",   bus.gen_out,   8'h30);
    chk("t1_prop",  bus.prop_out,  8'hCC);
    chk("t1_cin",   bus.cin_out,   1);
    chk("t1_allp",  bus.all_prop,  0);
    step();
    chk("t1_drained", bus.out_valid, 0);

    // 2: all-propagate and all-generate words
    drive(8'hAA, 8'h55, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("t2a_valid", bus.out_valid, 1);
    chk("t2a_gen",   bus.gen_out,   8'h00);
    chk("t2a_prop",  bus.prop_out,  8'hFF);
    chk("t2a_cin",   bus.cin_out,   0);
    chk("t2a_allp",  bus.all_prop,  1);
    step();
    drive(8'hFF, 8'hFF, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("t2b_gen",  bus.gen_out,  8'hFF);
    chk("t2b_prop", bus.prop_out, 8'h00);
    chk("t2b_cin",  bus.cin_out,  1);
    chk("t2b_allp", bus.all_prop, 0);
    step();
    chk("t2_drained", bus.out_valid, 0);

    // 3: streaming 16 beats back to back
    for (int t = 0; t <= 16; t++) begin
      if (t < 16) begin
        ea = 8'(t);
        drive(ea, ~ea, ea[0]);
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("t3_in_ready", bus.in_ready, 1);
      if (t > 0) begin
        chk("t3_valid", bus.out_valid, 1);
        chk("t3_gen",   bus.gen_out,   8'h00);
        chk("t3_prop",  bus.prop_out,  8'hFF);
        chk("t3_allp",  bus.all_prop,  1);
        chk("t3_cin",   bus.cin_out,   32'((t - 1) % 2));
      end
      step();
    end
    chk("t3_drained", bus.out_valid, 0);

    // 4: backpressure into FULL, then release in order
    bus.out_ready = 1'b0;
    drive(8'h01, 8'h02, 1'b0);
    step();
    drive(8'h03, 8'h04, 1'b1);
    step();
    chk("t4_full_in_ready", bus.in_ready, 0);
    drive(8'h10, 8'h30, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t4_stall_valid", bus.out_valid, 1);
      chk("t4_stall_gen",   bus.gen_out,   8'h00);
      chk("t4_stall_prop",  bus.prop_out,  8'h03);
      chk("t4_stall_cin",   bus.cin_out,   0);
      chk("t4_stall_ready", bus.in_ready,  0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("t4_y_prop",  bus.prop_out, 8'h07);
    chk("t4_y_gen",   bus.gen_out,  8'h00);
    chk("t4_y_cin",   bus.cin_out,  1);
    chk("t4_y_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("t4_z_valid", bus.out_valid, 1);
    chk("t4_z_gen",   bus.gen_out,   8'h10);
    chk("t4_z_prop",  bus.prop_out,  8'h20);
    step();
    chk("t4_drained", bus.out_valid, 0);

    // 5: asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(8'hFF, 8'hFF, 1'b1);
    step();
    drive(8'h0F, 8'h0F, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("t5_full", bus.in_ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", bus.out_valid, 0);
    chk("t5_async_gen",   bus.gen_out,   0);
    chk("t5_async_ready", bus.in_ready,  1);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_ghost", bus.out_valid, 0);
      chk("t5_ready",    bus.in_ready,  1);
    end

    // 6: random valid/ready with scoreboard
    sent = 0;
    recv = 0;
    holding = 1'b0;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      chk("t6_in_ready",  bus.in_ready,  32'(exp_q.size() < 2));
      chk("t6_out_valid", bus.out_valid, 32'(exp_q.size() != 0));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!holding) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          drive(8'($urandom), 8'($urandom), 1'($urandom));
        end else begin
          bus.in_valid = 1'b0;
          bus.a        = 'x;
          bus.b        = 'x;
          bus.carry_in = 'x;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        head = exp_q.pop_front();
        ea = head[16:9];
        eb = head[8:1];
        chk("t6_gen",  bus.gen_out,  ea & eb);
        chk("t6_prop", bus.prop_out, ea ^ eb);
        chk("t6_cin",  bus.cin_out,  head[0]);
        chk("t6_allp", bus.all_prop, &(ea ^ eb));
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.a, bus.b, bus.carry_in});
        sent++;
        holding = 1'b0;
      end else begin
        holding = bus.in_valid;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("t6_received", recv, 1000);
    chk("t6_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
